// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: register-file geometry and the
// writeback request record passed between pipeline stages.
package mips_pkg;

    localparam int                    REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO   = 5'd0;
    localparam int                    DATA_W     = 32;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order FIFO used by the writeback queue. Holds packed {addr, data}
// entries, tracks occupancy, and exposes its raw storage plus the head
// pointer so the parent can search pending writes for bypassing.
module wb_fifo #(
    parameter  int WIDTH   = 37,
    parameter  int DEPTH   = 4,
    parameter  int LEVEL_W = 5,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [LEVEL_W-1:0]           level,
    output logic [PTR_W-1:0]             head_ptr,
    output logic [DEPTH-1:0][WIDTH-1:0]  entries
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PTR_W-1:0]            wr_ptr;
    logic [PTR_W-1:0]            rd_ptr;

    // Entry storage, written at the tail on push.
    // NOTE: storage has no reset; level gates every use of an entry, so stale
    // contents are never observed and the array stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    // NOTE: non-blocking assignments so every flop samples pre-edge values,
    // independent of the order these statements are evaluated in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: ;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign head_ptr = rd_ptr;
    assign entries  = mem;

endmodule

// File: rtl/rf_writeback_queue.sv
// Register-file writeback queue: arbitrates two writeback sources (src0 = ALU
// has priority over src1 = load/MDU), drops writes to $zero, buffers requests
// in order and retires one per cycle through a registered WE3/A3/WD3 port.
// Optional feature macro RF_WBQ_BYPASS_EN: when defined, two combinational
// lookups return the youngest pending value for a decode read address; when
// undefined the bypass outputs are tied to zero.
module rf_writeback_queue
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src0_valid,
    input  logic [ADDR_WIDTH-1:0] src0_addr,
    input  logic [DATA_WIDTH-1:0] src0_data,
    output logic                  src0_ready,
    input  logic                  src1_valid,
    input  logic [ADDR_WIDTH-1:0] src1_addr,
    input  logic [DATA_WIDTH-1:0] src1_data,
    output logic                  src1_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  byp_hit_a,
    output logic [DATA_WIDTH-1:0] byp_data_a,
    output logic                  byp_hit_b,
    output logic [DATA_WIDTH-1:0] byp_data_b,
    output logic [ADDR_WIDTH-1:0] level,
    output logic                  empty
);

    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;
    localparam int PTR_W   = $clog2(DEPTH);

    logic                            full;
    logic                            acc0;
    logic                            acc1;
    logic                            push;
    logic                            pop;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [DATA_WIDTH-1:0]           sel_data;
    logic [ENTRY_W-1:0]              pop_entry;
    logic [PTR_W-1:0]                head_ptr;
    logic [DEPTH-1:0][ENTRY_W-1:0]   entries;

    // Ready depends only on occupancy, never on the same-cycle pop.
    assign full       = (level == ADDR_WIDTH'(DEPTH));
    assign src0_ready = !full;
    assign src1_ready = !full && !src0_valid;

    // Fixed-priority arbitration; an accepted write to $zero is swallowed.
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        acc0     = src0_valid && src0_ready;
        acc1     = src1_valid && src1_ready;
        sel_addr = src1_addr;
        sel_data = src1_data;
        if (acc0) begin
            sel_addr = src0_addr;
            sel_data = src0_data;
        end
        push = (acc0 || acc1) && (sel_addr != ADDR_WIDTH'(REG_ZERO));
    end

    // Drain continuously: any buffered entry retires on the next edge.
    assign pop = (level != '0);

    wb_fifo #(
        .WIDTH   (ENTRY_W),
        .DEPTH   (DEPTH),
        .LEVEL_W (ADDR_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({sel_addr, sel_data}),
        .pop       (pop),
        .pop_data  (pop_entry),
        .level     (level),
        .head_ptr  (head_ptr),
        .entries   (entries)
    );

    // Registered register-file write port; address/data hold when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= pop;
            if (pop) begin
                wr_addr <= pop_entry[ENTRY_W-1 -: ADDR_WIDTH];
                wr_data <= pop_entry[DATA_WIDTH-1:0];
            end
        end
    end

    assign empty = (level == '0) && !wr_en;

`ifdef RF_WBQ_BYPASS_EN
    logic [1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [1:0]                 hit_vec;
    logic [1:0][DATA_WIDTH-1:0] data_vec;
    logic [PTR_W-1:0]           idx;

    assign rd_addr = {rd_addr_b, rd_addr_a};

    // Youngest-match search: the port register is oldest, then FIFO entries
    // head to tail, so later matches overwrite earlier ones.
    always_comb begin
        hit_vec  = '0;
        data_vec = '0;
        idx      = '0;
        for (int p = 0; p < 2; p++) begin
            if (rd_addr[p] != ADDR_WIDTH'(REG_ZERO)) begin
                if (wr_en && (wr_addr == rd_addr[p])) begin
                    hit_vec[p]  = 1'b1;
                    data_vec[p] = wr_data;
                end
                for (int k = 0; k < DEPTH; k++) begin
                    idx = head_ptr + PTR_W'(k);
                    if ((ADDR_WIDTH'(k) < level) &&
                        (entries[idx][ENTRY_W-1 -: ADDR_WIDTH] == rd_addr[p])) begin
                        hit_vec[p]  = 1'b1;
                        data_vec[p] = entries[idx][DATA_WIDTH-1:0];
                    end
                end
            end
        end
    end

    assign byp_hit_a  = hit_vec[0];
    assign byp_data_a = data_vec[0];
    assign byp_hit_b  = hit_vec[1];
    assign byp_data_b = data_vec[1];
`else
    assign byp_hit_a  = 1'b0;
    assign byp_data_a = '0;
    assign byp_hit_b  = 1'b0;
    assign byp_data_b = '0;

    // Lookup inputs and FIFO visibility are intentionally unused in this build.
    logic unused_byp;
    assign unused_byp = ^{rd_addr_a, rd_addr_b, head_ptr, entries};
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue. A queue-based reference model
// tracks pending writes and the register-file port; directed tasks cover the
// documented scenarios and a randomized task exercises collisions and $zero.
module tb_rf_writeback_queue;
    import mips_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          src0_valid, src1_valid;
    logic [AW-1:0] src0_addr, src1_addr;
    logic [DW-1:0] src0_data, src1_data;
    logic          src0_ready, src1_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_addr_a, rd_addr_b;
    logic          byp_hit_a, byp_hit_b;
    logic [DW-1:0] byp_data_a, byp_data_b;
    logic [AW-1:0] level;
    logic          empty;

    int n_cmp;
    int n_err;

    // Reference model: buffered requests plus the register-file port state.
    wb_req_t       m_q[$];
    logic          m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;

    rf_writeback_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .src0_valid (src0_valid),
        .src0_addr  (src0_addr),
        .src0_data  (src0_data),
        .src0_ready (src0_ready),
        .src1_valid (src1_valid),
        .src1_addr  (src1_addr),
        .src1_data  (src1_data),
        .src1_ready (src1_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .byp_hit_a  (byp_hit_a),
        .byp_data_a (byp_data_a),
        .byp_hit_b  (byp_hit_b),
        .byp_data_b (byp_data_b),
        .level      (level),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_q.delete();
        m_wr_en   = 1'b0;
        m_wr_addr = '0;
        m_wr_data = '0;
    endtask

    task automatic idle_inputs();
        src0_valid = 1'b0; src0_addr = '0; src0_data = '0;
        src1_valid = 1'b0; src1_addr = '0; src1_data = '0;
    endtask

    // Youngest pending value for a read address (search newest first).
    function automatic void model_byp(input logic [AW-1:0] ra, output logic hit,
                                      output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef RF_WBQ_BYPASS_EN
        if (ra != 0) begin
            for (int i = m_q.size() - 1; i >= 0 && !hit; i--) begin
                if (m_q[i].addr == ra) begin
                    hit = 1'b1;
                    d   = m_q[i].data;
                end
            end
            if (!hit && m_wr_en && m_wr_addr == ra) begin
                hit = 1'b1;
                d   = m_wr_data;
            end
        end
`endif
    endfunction

    // Advance one clock: apply the model's rules to the current inputs, then
    // return on the following falling edge.
    task automatic tick();
        bit      full;
        wb_req_t req;
        full = (m_q.size() >= DEPTH);
        if (m_q.size() > 0) begin
            req       = m_q.pop_front();
            m_wr_en   = 1'b1;
            m_wr_addr = req.addr;
            m_wr_data = req.data;
        end else begin
            m_wr_en = 1'b0;
        end
        if (!full && src0_valid) begin
            if (src0_addr != 0) m_q.push_back('{addr: src0_addr, data: src0_data});
        end else if (!full && src1_valid) begin
            if (src1_addr != 0) m_q.push_back('{addr: src1_addr, data: src1_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        rd_addr_a = '0;
        rd_addr_b = '0;
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
        n_cmp++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
        n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL reset_src0_ready: got %b want 1", src0_ready); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 32'h1234;
        #1;
        n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", src0_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_e1: got %b want 0", wr_en); end
        n_cmp++; if (level !== 5'd1) begin n_err++; $display("FAIL single_level_e1: got %0d want 1", level); end
        tick();
        n_cmp++; if (wr_en !== 1'b1) begin n_err++; $display("FAIL single_wr_en_e2: got %b want 1", wr_en); end
        n_cmp++; if (wr_addr !== 5'd5) begin n_err++; $display("FAIL single_wr_addr: got %0d want 5", wr_addr); end
        n_cmp++; if (wr_data !== 32'h1234) begin n_err++; $display("FAIL single_wr_data: got %h want 1234", wr_data); end
        n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL single_empty_e2: got %b want 0", empty); end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL single_wr_en_e3: got %b want 0", wr_en); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL single_empty_e3: got %b want 1", empty); end
        n_cmp++; if (wr_addr !== 5'd5) begin n_err++; $display("FAIL single_addr_hold: got %0d want 5", wr_addr); end
    endtask

    task automatic test_priority();
        src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 32'hA3;
        src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 32'hB4;
        #1;
        n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL prio_src0_ready: got %b want 1", src0_ready); end
        n_cmp++; if (src1_ready !== 1'b0) begin n_err++; $display("FAIL prio_src1_ready: got %b want 0", src1_ready); end
        tick();
        src0_valid = 1'b0;
        #1;
        n_cmp++; if (src1_ready !== 1'b1) begin n_err++; $display("FAIL prio_src1_ready_later: got %b want 1", src1_ready); end
        tick();
        src1_valid = 1'b0;
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd3 || wr_data !== 32'hA3) begin
            n_err++; $display("FAIL prio_first: got en=%b a=%0d d=%h want en=1 a=3 d=a3", wr_en, wr_addr, wr_data);
        end
        tick();
        n_cmp++; if (wr_en !== 1'b1 || wr_addr !== 5'd4 || wr_data !== 32'hB4) begin
            n_err++; $display("FAIL prio_second: got en=%b a=%0d d=%h want en=1 a=4 d=b4", wr_en, wr_addr, wr_data);
        end
        tick();
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL prio_drained: got %b want 0", wr_en); end
    endtask

    // src0 held valid with a stream of requests while src1 waits; every request
    // must retire exactly once, in accept order, and level must stay in range.
    task automatic test_back_to_back();
        int n_ret;
        n_ret = 0;
        src1_valid = 1'b1; src1_addr = 5'd9; src1_data = 32'h9999;
        for (int i = 0; i < 10; i++) begin
            src0_valid = (i < 8);
            src0_addr  = AW'(i + 1);
            src0_data  = 32'h100 + i;
            if (i == 8) src1_valid = 1'b1;
            #1;
            n_cmp++; if (src0_ready !== (m_q.size() < DEPTH)) begin
                n_err++; $display("FAIL b2b_ready[%0d]: got %b want %b", i, src0_ready, m_q.size() < DEPTH);
            end
            tick();
            if (i == 8) src1_valid = 1'b0;
            if (wr_en) n_ret++;
            n_cmp++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
                n_err++; $display("FAIL b2b_port[%0d]: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                                  i, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
            end
            n_cmp++; if (level > DEPTH || level !== AW'(m_q.size())) begin
                n_err++; $display("FAIL b2b_level[%0d]: got %0d want %0d", i, level, m_q.size());
            end
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            if (wr_en) n_ret++;
        end
        n_cmp++; if (n_ret !== 9) begin n_err++; $display("FAIL b2b_count: got %0d want 9", n_ret); end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL b2b_empty: got %b want 1", empty); end
    endtask

    task automatic test_zero_drop();
        src0_valid = 1'b1; src0_addr = 5'd0; src0_data = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (src0_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", src0_ready); end
        tick();
        idle_inputs();
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL zero_level: got %0d want 0", level); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL zero_wr_en[%0d]: got %b want 0", i, wr_en); end
            tick();
        end
    endtask

    task automatic test_bypass();
        logic          eh;
        logic [DW-1:0] ed_first, ed_second;
`ifdef RF_WBQ_BYPASS_EN
        eh = 1'b1; ed_first = 32'h11; ed_second = 32'h22;
`else
        eh = 1'b0; ed_first = '0; ed_second = '0;
`endif
        rd_addr_a = 5'd7;
        rd_addr_b = 5'd0;
        src0_valid = 1'b1; src0_addr = 5'd7; src0_data = 32'h11;
        tick();
        src0_data = 32'h22;
        #1;
        n_cmp++; if (byp_hit_a !== eh || byp_data_a !== ed_first) begin
            n_err++; $display("FAIL byp_first: got hit=%b d=%h want hit=%b d=%h", byp_hit_a, byp_data_a, eh, ed_first);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (byp_hit_a !== eh || byp_data_a !== ed_second) begin
            n_err++; $display("FAIL byp_youngest: got hit=%b d=%h want hit=%b d=%h", byp_hit_a, byp_data_a, eh, ed_second);
        end
        n_cmp++; if (byp_hit_b !== 1'b0 || byp_data_b !== '0) begin
            n_err++; $display("FAIL byp_zero_b: got hit=%b d=%h want hit=0 d=0", byp_hit_b, byp_data_b);
        end
        tick();
        #1;
        n_cmp++; if (byp_hit_a !== eh || byp_data_a !== ed_second) begin
            n_err++; $display("FAIL byp_port: got hit=%b d=%h want hit=%b d=%h", byp_hit_a, byp_data_a, eh, ed_second);
        end
        tick();
        #1;
        n_cmp++; if (byp_hit_a !== 1'b0) begin n_err++; $display("FAIL byp_drained: got %b want 0", byp_hit_a); end
        rd_addr_a = '0;
    endtask

    task automatic test_random();
        logic          eh;
        logic [DW-1:0] ed;
        for (int c = 0; c < 400; c++) begin
            src0_valid = ($urandom_range(0, 2) == 0);
            src0_addr  = AW'($urandom_range(0, 7));
            src0_data  = $urandom;
            src1_valid = ($urandom_range(0, 1) == 0);
            src1_addr  = AW'($urandom_range(0, 7));
            src1_data  = $urandom;
            rd_addr_a  = AW'($urandom_range(0, 7));
            rd_addr_b  = AW'($urandom_range(0, 7));
            #1;
            n_cmp++; if (src0_ready !== (m_q.size() < DEPTH) ||
                         src1_ready !== (m_q.size() < DEPTH && !src0_valid)) begin
                n_err++; $display("FAIL rnd_ready[%0d]: got %b/%b", c, src0_ready, src1_ready);
            end
            model_byp(rd_addr_a, eh, ed);
            n_cmp++; if (byp_hit_a !== eh || (eh && byp_data_a !== ed)) begin
                n_err++; $display("FAIL rnd_byp_a[%0d]: got hit=%b d=%h want hit=%b d=%h", c, byp_hit_a, byp_data_a, eh, ed);
            end
            model_byp(rd_addr_b, eh, ed);
            n_cmp++; if (byp_hit_b !== eh || (eh && byp_data_b !== ed)) begin
                n_err++; $display("FAIL rnd_byp_b[%0d]: got hit=%b d=%h want hit=%b d=%h", c, byp_hit_b, byp_data_b, eh, ed);
            end
            tick();
            n_cmp++; if (wr_en !== m_wr_en || wr_addr !== m_wr_addr || wr_data !== m_wr_data) begin
                n_err++; $display("FAIL rnd_port[%0d]: got en=%b a=%0d d=%h want en=%b a=%0d d=%h",
                                  c, wr_en, wr_addr, wr_data, m_wr_en, m_wr_addr, m_wr_data);
            end
            n_cmp++; if (level !== AW'(m_q.size()) || empty !== (m_q.size() == 0 && !m_wr_en)) begin
                n_err++; $display("FAIL rnd_level[%0d]: got level=%0d empty=%b want level=%0d", c, level, empty, m_q.size());
            end
        end
        idle_inputs();
        rd_addr_a = '0;
        rd_addr_b = '0;
    endtask

    // Asynchronous reset in the middle of a cycle while writes are in flight.
    task automatic test_reset_mid_drain();
        src0_valid = 1'b1; src0_addr = 5'd12; src0_data = 32'hC0DE;
        tick();
        src0_addr = 5'd13; src0_data = 32'hBEEF;
        tick();
        idle_inputs();
        n_cmp++; if (wr_en !== 1'b1 || level !== 5'd1) begin
            n_err++; $display("FAIL rst_setup: got en=%b level=%0d want en=1 level=1", wr_en, level);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
        n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        n_cmp++; if (wr_addr !== '0 || wr_data !== '0) begin
            n_err++; $display("FAIL rst_port: got a=%0d d=%h want 0/0", wr_addr, wr_data);
        end
        n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b want 1", empty); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (wr_en !== 1'b0) begin n_err++; $display("FAIL rst_no_write[%0d]: got %b want 0", i, wr_en); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_priority();
        test_back_to_back();
        test_zero_drop();
        test_bypass();
        test_random();
        test_reset_mid_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
